// File: rtl/vga_fb_scanner.sv
// 640x480@60 framebuffer scan-out: raster address generation, sync timing, RGB realignment.
// Optional colour-bar generator enabled by VGA_FB_TEST_PATTERN_EN.
module vga_fb_scanner #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter int          IMG_W    = 256,
  parameter int          IMG_H    = 256,
  parameter int          IMG_X0   = 192,
  parameter int          IMG_Y0   = 112,
  parameter int          RAM_LAT  = 1,
  parameter logic [23:0] BORDER   = 24'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [15:0] fb_addr,
  input  logic [31:0] fb_data,
  input  logic        pattern_sel,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [23:0] rgb,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int XW      = $clog2(IMG_W);
  localparam int YW      = 16 - XW;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       vis;
    logic       img;
    logic       first;
`ifdef VGA_FB_TEST_PATTERN_EN
    logic [2:0] bar;
`endif
  } flg_t;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;
  logic          en_q;
  logic          in_img;
  logic [XW-1:0] x_off;
  logic [YW-1:0] y_off;
  logic [15:0]   addr_q;
  flg_t          cur;
  flg_t          pipe [RAM_LAT];
  flg_t          d;
  logic [23:0]   pix;
  logic          unused_ok;

  assign h_last = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last = (v_cnt == VW'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
      en_q  <= 1'b0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + HW'(1);
      if (h_last)
        v_cnt <= v_last ? '0 : v_cnt + VW'(1);
      if (h_last && v_last)
        en_q <= enable;
    end
  end

  assign in_img = en_q
    && (h_cnt >= HW'(IMG_X0))
    && (h_cnt <= HW'(IMG_X0 + IMG_W - 1))
    && (v_cnt >= VW'(IMG_Y0))
    && (v_cnt <= VW'(IMG_Y0 + IMG_H - 1));

  // IMG_W is a power of two, so the row offset is a plain concatenation
  assign x_off   = XW'(h_cnt) - XW'(IMG_X0);
  assign y_off   = YW'(v_cnt) - YW'(IMG_Y0);
  assign fb_addr = in_img ? {y_off, x_off} : addr_q;

  always_ff @(posedge clk) begin
    if (reset)
      addr_q <= '0;
    else
      addr_q <= fb_addr;
  end

  always_comb begin
    cur       = '0;
    cur.hs    = (h_cnt >= HW'(H_ACTIVE + H_FP))
             && (h_cnt <= HW'(H_ACTIVE + H_FP + H_SYNC - 1));
    cur.vs    = (v_cnt >= VW'(V_ACTIVE + V_FP))
             && (v_cnt <= VW'(V_ACTIVE + V_FP + V_SYNC - 1));
    cur.vis   = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    cur.img   = in_img;
    cur.first = (h_cnt == '0) && (v_cnt == '0);
`ifdef VGA_FB_TEST_PATTERN_EN
    cur.bar   = 3'(h_cnt / HW'(H_ACTIVE / 8));
`endif
  end

  // sync flags travel active-high so a cleared stage means "inactive"
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RAM_LAT; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= cur;
      for (int i = 1; i < RAM_LAT; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign d = pipe[RAM_LAT-1];

  always_comb begin
    pix = 24'h0;
    if (d.img)
      pix = fb_data[23:0];
    else if (d.vis)
      pix = BORDER;
`ifdef VGA_FB_TEST_PATTERN_EN
    if (pattern_sel && d.vis)
      pix = {{8{~d.bar[1]}}, {8{~d.bar[2]}}, {8{~d.bar[0]}}};
`endif
  end

`ifdef VGA_FB_TEST_PATTERN_EN
  assign unused_ok = ^fb_data[31:24];
`else
  assign unused_ok = ^{fb_data[31:24], pattern_sel};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      rgb         <= 24'h0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= ~d.hs;
      vsync       <= ~d.vs;
      de          <= d.vis;
      rgb         <= pix;
      frame_start <= d.first;
    end
  end

endmodule

// File: tb/tb_vga_fb_scanner.sv
// Directed bench for vga_fb_scanner using a shrunken raster and a 2-cycle RAM.
// Pattern expectations follow VGA_FB_TEST_PATTERN_EN.
module tb_vga_fb_scanner;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 16, VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int LAT = 2;
  localparam int L = LAT + 1;
  localparam logic [23:0] B = 24'h123456;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        pattern_sel = 1'b0;
  logic [15:0] fb_addr;
  logic [31:0] fb_data;
  logic        hsync, vsync, de, frame_start;
  logic [23:0] rgb;

  int tests = 0;
  int fails = 0;
  int idx = 0;

  vga_fb_scanner #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .IMG_W(16), .IMG_H(8), .IMG_X0(20), .IMG_Y0(4),
    .RAM_LAT(LAT), .BORDER(B)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .fb_addr(fb_addr), .fb_data(fb_data),
    .pattern_sel(pattern_sel),
    .hsync(hsync), .vsync(vsync), .de(de),
    .rgb(rgb), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  logic [31:0] rpipe [LAT];
  always @(posedge clk) begin
    rpipe[0] <= {8'hFF, 8'hA0, fb_addr[7:0], 8'h3C};
    for (int i = 1; i < LAT; i++)
      rpipe[i] <= rpipe[i-1];
  end
  assign fb_data = rpipe[LAT-1];

  always @(posedge clk) begin
    if (reset)
      idx <= 0;
    else
      idx <= (idx == FT - 1) ? 0 : idx + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic rst_q = 1'b1;
  int   hs_run = 0, vs_run = 0, fs_gap = 0;
  bit   fs_seen = 0;
  always @(posedge clk) rst_q <= reset;
  always @(negedge clk) begin
    if (rst_q) begin
      chk("fs_in_reset", {31'd0, frame_start}, 32'd0);
      fs_seen = 0;
      hs_run  = 0;
      vs_run  = 0;
    end else begin
      fs_gap++;
      if (frame_start === 1'b1) begin
        if (fs_seen) chk("fs_period", fs_gap, FT);
        fs_seen = 1;
        fs_gap  = 0;
      end
      if (hsync === 1'b0) hs_run++;
      else begin
        if (hs_run != 0) chk("hs_width", hs_run, HS);
        hs_run = 0;
      end
      if (vsync === 1'b0) vs_run++;
      else begin
        if (vs_run != 0) chk("vs_width", vs_run, VS * HT);
        vs_run = 0;
      end
    end
  end

  task automatic wait_idx(input string nm, input int t);
    int n = 0;
    while (idx != t && n < 2 * FT + 4) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (idx != t) begin
      fails++;
      $display("FAIL %s: timeout got idx %0d expected %0d", nm, idx, t);
    end
  endtask

  typedef struct {
    bit          pin;
    int          x;
    int          y;
    logic        en;
    logic [15:0] addr;
    logic        de, hs, vs, fs;
    logic [23:0] rgb;
  } vec_t;

  vec_t vq[$];

  function automatic void addv(int x, int y, logic en, logic [15:0] a);
    vec_t v;
    v = '{0, x, y, en, a, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0};
    vq.push_back(v);
  endfunction

  function automatic void pinv(int x, int y, logic en, logic e_de,
                               logic e_hs, logic e_vs, logic e_fs,
                               logic [23:0] e_rgb);
    vec_t v;
    v = '{1, x, y, en, 16'h0, e_de, e_hs, e_vs, e_fs, e_rgb};
    vq.push_back(v);
  endfunction

  task automatic pix_chk(input string nm, input int x, input int y,
                         input logic e_de, input logic [23:0] e_rgb);
    wait_idx(nm, y * HT + x + L);
    chk({nm, " de"}, {31'd0, de}, {31'd0, e_de});
    chk({nm, " rgb"}, {8'd0, rgb}, {8'd0, e_rgb});
  endtask

  logic [23:0] exp_p0, exp_p10, exp_p63;

  initial begin
    // frame 1: en_q still 0 after reset
    pinv(0, 0, 1, 1, 1, 1, 1, B);
    pinv(67, 0, 1, 0, 1, 1, 0, 24'h0);
    pinv(68, 0, 1, 0, 0, 1, 0, 24'h0);
    pinv(75, 0, 1, 0, 0, 1, 0, 24'h0);
    pinv(76, 0, 1, 0, 1, 1, 0, 24'h0);
    addv(20, 4, 1, 16'h0000);
    pinv(20, 4, 1, 1, 1, 1, 0, B);
    pinv(79, 17, 1, 0, 1, 1, 0, 24'h0);
    pinv(0, 18, 1, 0, 1, 0, 0, 24'h0);
    pinv(0, 20, 1, 0, 1, 1, 0, 24'h0);
    // frame 2: image on, enable dropped mid-frame
    pinv(5, 2, 1, 1, 1, 1, 0, B);
    pinv(70, 2, 1, 0, 0, 1, 0, 24'h0);
    addv(20, 4, 1, 16'h0000);
    pinv(20, 4, 1, 1, 1, 1, 0, 24'hA0003C);
    addv(35, 4, 1, 16'h000F);
    addv(36, 4, 1, 16'h000F);
    pinv(35, 4, 1, 1, 1, 1, 0, 24'hA00F3C);
    pinv(36, 4, 1, 1, 1, 1, 0, B);
    addv(20, 5, 0, 16'h0010);
    pinv(20, 5, 0, 1, 1, 1, 0, 24'hA0103C);
    addv(35, 11, 0, 16'h007F);
    pinv(35, 11, 0, 1, 1, 1, 0, 24'hA07F3C);
    addv(0, 12, 0, 16'h007F);
    pinv(0, 12, 0, 1, 1, 1, 0, B);
    // frame 3: image off, enable raised mid-frame
    addv(20, 4, 0, 16'h007F);
    pinv(20, 4, 0, 1, 1, 1, 0, B);
    addv(0, 8, 1, 16'h007F);
    pinv(25, 9, 1, 1, 1, 1, 0, B);
    // frame 4: image back
    addv(25, 9, 1, 16'h0055);
    pinv(25, 9, 1, 1, 1, 1, 0, 24'hA0553C);

    repeat (3) @(negedge clk);
    chk("rst hsync", {31'd0, hsync}, 32'd1);
    chk("rst vsync", {31'd0, vsync}, 32'd1);
    chk("rst de", {31'd0, de}, 32'd0);
    chk("rst rgb", {8'd0, rgb}, 32'd0);
    chk("rst fs", {31'd0, frame_start}, 32'd0);
    chk("rst addr", {16'd0, fb_addr}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      string nm;
      nm = $sformatf("v%0d(%0d,%0d)", i, vq[i].x, vq[i].y);
      if (vq[i].pin) begin
        wait_idx(nm, vq[i].y * HT + vq[i].x + L);
        chk({nm, " de"}, {31'd0, de}, {31'd0, vq[i].de});
        chk({nm, " hsync"}, {31'd0, hsync}, {31'd0, vq[i].hs});
        chk({nm, " vsync"}, {31'd0, vsync}, {31'd0, vq[i].vs});
        chk({nm, " fs"}, {31'd0, frame_start}, {31'd0, vq[i].fs});
        chk({nm, " rgb"}, {8'd0, rgb}, {8'd0, vq[i].rgb});
      end else begin
        wait_idx(nm, vq[i].y * HT + vq[i].x);
        chk({nm, " addr"}, {16'd0, fb_addr}, {16'd0, vq[i].addr});
      end
      enable = vq[i].en;
    end

    // reset pulse mid-frame while an image pixel is on the pins
    wait_idx("pre_rst", 6 * HT + 30);
    chk("pre_rst rgb", {8'd0, rgb}, {8'd0, 24'hA0273C});
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst hsync", {31'd0, hsync}, 32'd1);
    chk("mid_rst vsync", {31'd0, vsync}, 32'd1);
    chk("mid_rst de", {31'd0, de}, 32'd0);
    chk("mid_rst rgb", {8'd0, rgb}, 32'd0);
    chk("mid_rst fs", {31'd0, frame_start}, 32'd0);
    chk("mid_rst addr", {16'd0, fb_addr}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_idx("post_rst a", L - 1);
    chk("post_rst fs early", {31'd0, frame_start}, 32'd0);
    chk("post_rst rgb early", {8'd0, rgb}, 32'd0);
    wait_idx("post_rst b", L);
    chk("post_rst fs", {31'd0, frame_start}, 32'd1);
    chk("post_rst rgb", {8'd0, rgb}, {8'd0, B});
    wait_idx("post_rst c", L + 1);
    chk("post_rst fs once", {31'd0, frame_start}, 32'd0);

    pattern_sel = 1'b1;
`ifdef VGA_FB_TEST_PATTERN_EN
    exp_p0  = 24'hFFFFFF;
    exp_p10 = 24'hFFFF00;
    exp_p63 = 24'h000000;
`else
    exp_p0  = B;
    exp_p10 = B;
    exp_p63 = B;
`endif
    pix_chk("pat x0", 0, 1, 1'b1, exp_p0);
    pix_chk("pat x10", 10, 1, 1'b1, exp_p10);
    pix_chk("pat x63", 63, 1, 1'b1, exp_p63);
    pix_chk("pat blank", 70, 1, 1'b0, 24'h0);
    pattern_sel = 1'b0;

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
